// File: rtl/fifo_stream_reader.sv
// Consumer side of the synchronous FIFO: drives its read port and re-presents words as a valid/ready stream
// through a 2-entry buffer. Define FIFO_STREAM_READER_STATS_EN to add the words_out/stall_out counters.
module fifo_stream_reader #(
  parameter int unsigned WIDTH_BYTES = 4,
  parameter int unsigned SHOWAHEAD   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_empty_in,
  input  logic [WIDTH_BYTES*8-1:0] fifo_data_in,
  output logic                     fifo_read_out,
  output logic                     valid_out,
  output logic [WIDTH_BYTES*8-1:0] data_out,
  input  logic                     ready_in,
  input  logic                     clear_in,
  input  logic                     debugen_in
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0]              words_out,
  output logic [31:0]              stall_out
`endif
);

  localparam int unsigned W = WIDTH_BYTES * 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t       cnt_q, cnt_d;
  logic [W-1:0] buf_q [2];
  logic [W-1:0] buf_d [2];
  logic         head_q, head_d;
  logic         inflight_q, inflight_d;
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  logic         pop;
  logic         capture;
  logic         slot;
  logic [2:0]   occ;
  logic [2:0]   cnt_sum;

  always_comb begin
    pop     = valid_q & ready_in;
    occ     = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_read_out = !reset && !clear_in && !fifo_empty_in && (occ < 3'd2);

    if (SHOWAHEAD != 0) begin
      capture    = fifo_read_out;
      inflight_d = 1'b0;
    end else begin
      capture    = inflight_q & ~clear_in;
      inflight_d = fifo_read_out;
    end

    // Slot is the post-pop head plus the post-pop count, which reduces to head_q + cnt_q.
    slot    = head_q ^ cnt_q[0];
    cnt_sum = {1'b0, cnt_q} + {2'b00, capture} - {2'b00, pop};

    buf_d[0] = buf_q[0];
    buf_d[1] = buf_q[1];
    if (capture) begin
      buf_d[slot] = fifo_data_in;
    end
    head_d = head_q ^ pop;
    cnt_d  = state_t'(cnt_sum[1:0]);

    if (clear_in) begin
      cnt_d      = EMPTY;
      head_d     = 1'b0;
      inflight_d = 1'b0;
    end

    valid_d = (cnt_d != EMPTY);
    data_d  = buf_d[head_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= EMPTY;
      head_q     <= 1'b0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] words_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || clear_in) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop) begin
        words_q <= words_q + 32'd1;
      end
      if (valid_q && !ready_in) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign words_out = words_q;
  assign stall_out = stall_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !clear_in && (cnt_sum > 3'd2)) begin
      $display("%m: reader buffer overflow");
      $finish;
    end
    if (debugen_in) begin
      $display("%m: rd=%b fdata=%h valid=%b ready=%b data=%h cnt=%0d",
               fifo_read_out, fifo_data_in, valid_q, ready_in, data_q, cnt_q);
    end
  end
`endif

endmodule
